// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared widths and arbiter state encoding for the MIPS memory port
package mips_mem_pkg;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: 8-bit clear/enable counter flagging the cycle that would reach LIMIT
module mem_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expire = en && cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with fetch anti-starvation
module mem_port_arbiter import mips_mem_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  state_t state;
  logic [3:0] starve_cnt;
  logic gnt_i, gnt_d, expire;
  assign gnt_i = i_req && (!d_req || starve_cnt == SL);
  assign gnt_d = d_req && !gnt_i;
  mem_watchdog #(.LIMIT(TIMEOUT)) u_tmo (
    .clk(clk), .reset(reset), .clr(state == IDLE),
    .en(state != IDLE && !mem_ack), .expire(expire)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      starve_cnt <= '0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_adr <= '0;
      mem_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err <= 1'b0;
      if (state == IDLE) begin
        starve_cnt <= (!i_req || gnt_i) ? 4'd0 : (gnt_d && starve_cnt != SL) ? starve_cnt + 4'd1 : starve_cnt;
        if (gnt_i || gnt_d) begin
          state <= gnt_d ? GNT_D : GNT_I;
          mem_req <= 1'b1;
          mem_we <= gnt_d && d_we;
          mem_be <= gnt_d ? d_be : 4'hF;
          mem_adr <= gnt_d ? d_adr : i_adr;
          mem_wdata <= gnt_d ? d_wdata : '0;
        end
      end else if (mem_ack || expire) begin
        // a timeout returns zero data; an ack on the expiring cycle still wins
        state <= IDLE;
        mem_req <= 1'b0;
        err <= !mem_ack;
        i_ack <= state == GNT_I;
        d_ack <= state == GNT_D;
        if (state == GNT_I) i_rdata <= mem_ack ? mem_rdata : '0;
        if (state == GNT_D && !(mem_ack && mem_we)) d_rdata <= mem_ack ? mem_rdata : '0;
      end
    end
endmodule
